// File: rtl/fakeram7_1r1w_model.sv
// rtl/fakeram7_1r1w_model.sv - behavioural 1R1W SRAM macro model with zero-init sweep, bit mask, read pipe.
// Macros: FAKERAM_RDWR_FWD_EN (same-address write-to-read forwarding), FAKERAM_SPECIFY_EN (SDF specify block).
module fakeram7_1r1w_model #(
  parameter int BITS             = 21,
  parameter int WORD_DEPTH       = 64,
  parameter int ADDR_WIDTH       = 6,
  parameter int READ_LATENCY     = 1,
  parameter int CORRUPT_MEM_ON_X = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_ce_in,
  input  logic [ADDR_WIDTH-1:0] rd_addr_in,
  output logic [BITS-1:0]       rd_out,
  output logic                  rd_valid_out,
  input  logic                  wr_ce_in,
  input  logic [ADDR_WIDTH-1:0] wr_addr_in,
  input  logic [BITS-1:0]       wd_in,
  input  logic [BITS-1:0]       wmask_in,
  output logic                  init_done_out,
  output logic                  addr_err_out
);

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(WORD_DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_W  = (ADDR_WIDTH + 1)'(WORD_DEPTH);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   init_cnt_q, init_cnt_d;
  logic                    addr_err_q, addr_err_d;
  logic [READ_LATENCY-1:0] vld_q, vld_d;
  logic [BITS-1:0]         dat_q [READ_LATENCY];
  logic [BITS-1:0]         dat_d [READ_LATENCY];
  logic [BITS-1:0]         mem_q [WORD_DEPTH];

  logic            run, rd_oob, wr_oob, rd_fire, wr_fire, wr_x, rd_x;
  logic [BITS-1:0] wr_merged, rd_word;

  always_comb begin
    run       = (state_q == ST_RUN);
    rd_oob    = ({1'b0, rd_addr_in} >= DEPTH_W);
    wr_oob    = ({1'b0, wr_addr_in} >= DEPTH_W);
    rd_fire   = run && rd_ce_in;
    wr_fire   = run && wr_ce_in && !wr_oob;
    wr_x      = (CORRUPT_MEM_ON_X != 0) && run &&
                ($isunknown(wr_ce_in) || (wr_ce_in && $isunknown(wr_addr_in)));
    rd_x      = (CORRUPT_MEM_ON_X != 0) && $isunknown(rd_addr_in);
    wr_merged = (mem_q[wr_addr_in] & ~wmask_in) | (wd_in & wmask_in);
    rd_word   = mem_q[rd_addr_in];
`ifdef FAKERAM_RDWR_FWD_EN
    if (wr_fire && (wr_addr_in == rd_addr_in)) rd_word = wr_merged;
`endif
    if (rd_oob) rd_word = '0;
    if (rd_x)   rd_word = {BITS{1'bx}};
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    if (state_q == ST_INIT) begin
      init_cnt_d = init_cnt_q + 1'b1;
      if (init_cnt_q == LAST_IDX) begin
        state_d    = ST_RUN;
        init_cnt_d = '0;
      end
    end
    addr_err_d = addr_err_q | (run && ((rd_ce_in && rd_oob) || (wr_ce_in && wr_oob)));
  end

  // Each stage keeps its data when no valid arrives, so rd_out holds between results.
  always_comb begin
    vld_d    = '0;
    vld_d[0] = rd_fire;
    dat_d    = dat_q;
    if (rd_fire) dat_d[0] = rd_word;
    for (int k = 1; k < READ_LATENCY; k++) begin
      vld_d[k] = vld_q[k-1];
      if (vld_q[k-1]) dat_d[k] = dat_q[k-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
      addr_err_q <= 1'b0;
      vld_q      <= '0;
      for (int k = 0; k < READ_LATENCY; k++) dat_q[k] <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      addr_err_q <= addr_err_d;
      vld_q      <= vld_d;
      for (int k = 0; k < READ_LATENCY; k++) dat_q[k] <= dat_d[k];
    end
  end

  // Array is deliberately outside the reset domain; only the sweep clears it.
  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) begin
      mem_q[init_cnt_q] <= '0;
    end else if (wr_x) begin
      for (int i = 0; i < WORD_DEPTH; i++) mem_q[i] <= {BITS{1'bx}};
      $warning("fakeram7_1r1w_model: X on write control/address, array corrupted");
    end else if (wr_fire) begin
      mem_q[wr_addr_in] <= wr_merged;
    end
  end

  assign rd_out        = dat_q[READ_LATENCY-1];
  assign rd_valid_out  = vld_q[READ_LATENCY-1];
  assign init_done_out = run;
  assign addr_err_out  = addr_err_q;

`ifdef FAKERAM_SPECIFY_EN
  logic notifier;
  specify
    (clk *> rd_out) = (0, 0);
    $setuphold(posedge clk, rd_ce_in,   0, 0, notifier);
    $setuphold(posedge clk, rd_addr_in, 0, 0, notifier);
    $setuphold(posedge clk, wr_ce_in,   0, 0, notifier);
    $setuphold(posedge clk, wr_addr_in, 0, 0, notifier);
    $setuphold(posedge clk, wd_in,      0, 0, notifier);
    $setuphold(posedge clk, wmask_in,   0, 0, notifier);
  endspecify
`endif

endmodule

// File: tb/tb_fakeram7_1r1w_model.sv
// tb/tb_fakeram7_1r1w_model.sv - scoreboard bench: depth 64/lat 1, depth 48/lat 1, depth 64/lat 2 instances.
module tb_fakeram7_1r1w_model;

  typedef struct {
    logic [20:0] data;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_ce, wr_ce;
  logic [5:0]  rd_addr, wr_addr;
  logic [20:0] wd, wm;
  logic [20:0] rdo  [3];
  logic        vld  [3];
  logic        done [3];
  logic        err  [3];

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q [3][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fakeram7_1r1w_model #(.BITS(21), .WORD_DEPTH(64), .ADDR_WIDTH(6), .READ_LATENCY(1)) dut0 (
    .clk(clk), .rst(rst), .rd_ce_in(rd_ce), .rd_addr_in(rd_addr), .rd_out(rdo[0]),
    .rd_valid_out(vld[0]), .wr_ce_in(wr_ce), .wr_addr_in(wr_addr), .wd_in(wd), .wmask_in(wm),
    .init_done_out(done[0]), .addr_err_out(err[0]));

  fakeram7_1r1w_model #(.BITS(21), .WORD_DEPTH(48), .ADDR_WIDTH(6), .READ_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .rd_ce_in(rd_ce), .rd_addr_in(rd_addr), .rd_out(rdo[1]),
    .rd_valid_out(vld[1]), .wr_ce_in(wr_ce), .wr_addr_in(wr_addr), .wd_in(wd), .wmask_in(wm),
    .init_done_out(done[1]), .addr_err_out(err[1]));

  fakeram7_1r1w_model #(.BITS(21), .WORD_DEPTH(64), .ADDR_WIDTH(6), .READ_LATENCY(2)) dut2 (
    .clk(clk), .rst(rst), .rd_ce_in(rd_ce), .rd_addr_in(rd_addr), .rd_out(rdo[2]),
    .rd_valid_out(vld[2]), .wr_ce_in(wr_ce), .wr_addr_in(wr_addr), .wd_in(wd), .wmask_in(wm),
    .init_done_out(done[2]), .addr_err_out(err[2]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b0) begin
      for (int i = 0; i < 3; i++) begin
        if (vld[i] !== 1'b0) begin
          if (exp_q[i].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL dut%0d unexpected valid: got valid=%b data=0x%0h expected no valid", i, vld[i], rdo[i]);
          end else begin
            e = exp_q[i].pop_front();
            chk($sformatf("dut%0d rd_data", i), {11'd0, rdo[i]}, {11'd0, e.data});
            chk($sformatf("dut%0d rd_cycle", i), cyc, e.due);
          end
        end
      end
    end
  end

  // One cycle of stimulus; e64 is the expected word for depth-64 instances, e48 for depth 48.
  task automatic op(input logic rd, input logic [5:0] ra, input logic wr, input logic [5:0] wa,
                    input logic [20:0] d, input logic [20:0] m, input logic [20:0] e64, input logic [20:0] e48);
    rd_ce = rd; rd_addr = ra; wr_ce = wr; wr_addr = wa; wd = d; wm = m;
    if (rd) begin
      exp_q[0].push_back('{data: e64, due: cyc + 1});
      exp_q[1].push_back('{data: e48, due: cyc + 1});
      exp_q[2].push_back('{data: e64, due: cyc + 2});
    end
    @(negedge clk);
    rd_ce = 1'b0; wr_ce = 1'b0;
  endtask

  task automatic wait_init(input int t0);
    int r [3];
    r = '{-1, -1, -1};
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (cyc - t0 >= 40) begin rd_ce = 1'b0; wr_ce = 1'b0; end
      for (int i = 0; i < 3; i++) if (done[i] === 1'b1 && r[i] < 0) r[i] = cyc - t0;
      if (r[0] >= 0 && r[1] >= 0 && r[2] >= 0) break;
    end
    rd_ce = 1'b0; wr_ce = 1'b0;
    chk("dut0 init_done cycles", r[0], 64);
    chk("dut1 init_done cycles", r[1], 48);
    chk("dut2 init_done cycles", r[2], 64);
  endtask

  task automatic drain_check();
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) chk($sformatf("dut%0d pending reads", i), exp_q[i].size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    logic [20:0] e3;
    rst = 1'b1; rd_ce = 1'b0; wr_ce = 1'b0; rd_addr = '0; wr_addr = '0; wd = '0; wm = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset rd_valid", vld[0], 0);
    chk("reset rd_out", rdo[0], 0);
    chk("reset init_done", done[0], 0);
    chk("reset addr_err", err[0], 0);
    chk("reset rd_valid lat2", vld[2], 0);

    // Requests during INIT must be ignored: junk write to addr 5, reads with no valid.
    rst = 1'b0; t = cyc;
    rd_ce = 1'b1; rd_addr = 6'd5; wr_ce = 1'b1; wr_addr = 6'd5; wd = 21'h1FFFFF; wm = 21'h1FFFFF;
    wait_init(t);
    op(1, 6'd5, 0, 0, 0, 0, 21'h000000, 21'h000000);

    op(0, 0, 1, 6'd3, 21'h1FFFFF, 21'h1FFFFF, 0, 0);
    op(0, 0, 1, 6'd3, 21'h000000, 21'h0000FF, 0, 0);
    op(1, 6'd3, 0, 0, 0, 0, 21'h1FFF00, 21'h1FFF00);
    op(0, 0, 1, 6'd3, 21'h0A5A5A, 21'h0F000F, 0, 0);
    op(1, 6'd3, 0, 0, 0, 0, 21'h1AFF0A, 21'h1AFF0A);

`ifdef FAKERAM_RDWR_FWD_EN
    e3 = 21'h155555;
`else
    e3 = 21'h00AAAA;
`endif
    op(0, 0, 1, 6'd7, 21'h00AAAA, 21'h1FFFFF, 0, 0);
    op(1, 6'd7, 1, 6'd7, 21'h155555, 21'h1FFFFF, e3, e3);
    op(1, 6'd7, 0, 0, 0, 0, 21'h155555, 21'h155555);

    op(0, 0, 1, 6'd50, 21'h0F0F0F, 21'h1FFFFF, 0, 0);
    @(negedge clk);
    chk("dut1 addr_err after oob write", err[1], 1);
    chk("dut0 addr_err in range", err[0], 0);
    op(1, 6'd50, 0, 0, 0, 0, 21'h0F0F0F, 21'h000000);
    op(1, 6'd2, 0, 0, 0, 0, 21'h000000, 21'h000000);

    op(0, 0, 1, 6'd0, 21'h000011, 21'h1FFFFF, 0, 0);
    op(0, 0, 1, 6'd1, 21'h000022, 21'h1FFFFF, 0, 0);
    op(1, 6'd1, 1, 6'd2, 21'h000033, 21'h1FFFFF, 21'h000022, 21'h000022);
    op(1, 6'd0, 0, 0, 0, 0, 21'h000011, 21'h000011);
    op(1, 6'd1, 0, 0, 0, 0, 21'h000022, 21'h000022);
    op(1, 6'd2, 0, 0, 0, 0, 21'h000033, 21'h000033);
    op(1, 6'd3, 0, 0, 0, 0, 21'h1AFF0A, 21'h1AFF0A);
    drain_check();

    // Reset with a read in flight, then a second pulse 20 cycles into the sweep.
    rd_ce = 1'b1; rd_addr = 6'd3;
    @(posedge clk);
    #1 rst = 1'b1; rd_ce = 1'b0;
    for (int i = 0; i < 3; i++) exp_q[i].delete();
    #1;
    for (int i = 0; i < 3; i++) chk($sformatf("dut%0d valid on reset", i), vld[i], 0);
    chk("dut0 rd_out on reset", rdo[0], 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    #1 chk("mid-init reset valid", vld[0], 0);
    chk("mid-init reset init_done", done[0], 0);
    @(negedge clk);
    rst = 1'b0; t = cyc;
    wait_init(t);
    chk("dut1 addr_err cleared", err[1], 0);
    op(1, 6'd3, 0, 0, 0, 0, 21'h000000, 21'h000000);
    op(1, 6'd7, 0, 0, 0, 0, 21'h000000, 21'h000000);
    drain_check();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
